// File: rtl/uart_cfg.sv
// Configurable UART: one transmitter and one oversampling receiver on a single clock.
// Optional parity support is compiled in with `define UART_CFG_PARITY_EN.
module uart_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_CFG_PARITY_EN
  localparam logic PAR_EN = (PARITY != 0);
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_INC   = CW'(1);
  localparam logic [CW-1:0] SMP_0     = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP_1     = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP_2     = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_INC   = BW'(1);
  localparam logic [BW-1:0] DBIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SBIT_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  // Even parity is the plain XOR of the data; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [2:0]           tx_state_r;
  logic [CW-1:0]        tx_cnt_r;
  logic [BW-1:0]        tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_par_r;
  logic                 tx_r;
  logic                 tx_last_clk_s;

  assign tx_last_clk_s = (tx_cnt_r == CNT_LAST);
  assign tx_ready = ~rst & ((tx_state_r == ST_IDLE) |
                            ((tx_state_r == ST_STOP) & (tx_bit_r == SBIT_LAST) & tx_last_clk_s));
  assign tx = tx_r;

  // Transmit FSM; tx_r is loaded one cycle ahead so the line changes right at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= '0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          tx_cnt_r <= '0;
          if (tx_valid) begin
            tx_state_r <= ST_START;
            tx_shift_r <= tx_data;
            tx_par_r   <= parity_of(tx_data);
            tx_r       <= 1'b0;
          end else begin
            tx_r <= 1'b1;
          end
        end
        ST_START: begin
          if (tx_last_clk_s) begin
            tx_state_r <= ST_DATA;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_r       <= tx_shift_r[0];
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_INC;
          end
        end
        ST_DATA: begin
          if (tx_last_clk_s) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == DBIT_LAST) begin
              tx_bit_r   <= '0;
              tx_state_r <= PAR_EN ? ST_PARITY : ST_STOP;
              tx_r       <= PAR_EN ? tx_par_r : 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + BIT_INC;
              tx_shift_r <= tx_shift_r >> 1;
              tx_r       <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_INC;
          end
        end
        ST_PARITY: begin
          if (tx_last_clk_s) begin
            tx_state_r <= ST_STOP;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_r       <= 1'b1;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_INC;
          end
        end
        ST_STOP: begin
          if (tx_last_clk_s) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == SBIT_LAST) begin
              tx_bit_r <= '0;
              // tx_ready is high here, so tx_valid alone means a back-to-back handshake.
              if (tx_valid) begin
                tx_state_r <= ST_START;
                tx_shift_r <= tx_data;
                tx_par_r   <= parity_of(tx_data);
                tx_r       <= 1'b0;
              end else begin
                tx_state_r <= ST_IDLE;
                tx_r       <= 1'b1;
              end
            end else begin
              tx_bit_r <= tx_bit_r + BIT_INC;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_INC;
          end
        end
        default: begin
          tx_state_r <= ST_IDLE;
          tx_cnt_r   <= '0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  logic [1:0]           rx_sync_r;
  logic                 rx_s;
  logic [2:0]           rx_state_r;
  logic [CW-1:0]        rx_cnt_r;
  logic [BW-1:0]        rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic [1:0]           rx_samp_r;
  logic                 rx_par_bit_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 rx_ferr_r;
  logic                 rx_perr_r;
  logic                 rx_vote_s;
  logic                 rx_mid_s;
  logic                 rx_last_s;

  assign rx_s      = rx_sync_r[1];
  assign rx_vote_s = maj3(rx_samp_r[0], rx_samp_r[1], rx_s);
  assign rx_mid_s  = (rx_cnt_r == SMP_2);
  assign rx_last_s = (rx_cnt_r == CNT_LAST);

  assign rx_data       = rx_data_r;
  assign rx_valid      = rx_valid_r;
  assign rx_frame_err  = rx_ferr_r;
  assign rx_parity_err = rx_perr_r;

  // Two-flop synchroniser for the asynchronous serial input, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
    end
  end

  // Receive FSM: each bit is decided on the third of three mid-bit samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r   <= ST_IDLE;
      rx_cnt_r     <= '0;
      rx_bit_r     <= '0;
      rx_shift_r   <= '0;
      rx_samp_r    <= 2'b11;
      rx_par_bit_r <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      rx_ferr_r    <= 1'b0;
      rx_perr_r    <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (rx_cnt_r == SMP_0) rx_samp_r[0] <= rx_s;
      if (rx_cnt_r == SMP_1) rx_samp_r[1] <= rx_s;
      case (rx_state_r)
        ST_IDLE: begin
          rx_cnt_r <= '0;
          // The detecting cycle is count 0 of the start bit.
          if (!rx_s) begin
            rx_state_r <= ST_START;
            rx_cnt_r   <= CNT_INC;
          end
        end
        ST_START: begin
          if (rx_mid_s && rx_vote_s) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= '0;
          end else if (rx_last_s) begin
            rx_state_r <= ST_DATA;
            rx_cnt_r   <= '0;
            rx_bit_r   <= '0;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_INC;
          end
        end
        ST_DATA: begin
          if (rx_mid_s) rx_shift_r <= {rx_vote_s, rx_shift_r[DATA_BITS-1:1]};
          if (rx_last_s) begin
            rx_cnt_r <= '0;
            if (rx_bit_r == DBIT_LAST) begin
              rx_bit_r   <= '0;
              rx_state_r <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + BIT_INC;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_INC;
          end
        end
        ST_PARITY: begin
          if (rx_mid_s) rx_par_bit_r <= rx_vote_s;
          if (rx_last_s) begin
            rx_state_r <= ST_STOP;
            rx_cnt_r   <= '0;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_INC;
          end
        end
        ST_STOP: begin
          if (rx_mid_s) begin
            rx_valid_r <= 1'b1;
            rx_data_r  <= rx_shift_r;
            rx_ferr_r  <= ~rx_vote_s;
            rx_perr_r  <= PAR_EN & (rx_par_bit_r != parity_of(rx_shift_r));
            rx_state_r <= rx_vote_s ? ST_IDLE : ST_WAIT_HIGH;
            rx_cnt_r   <= '0;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_INC;
          end
        end
        ST_WAIT_HIGH: begin
          rx_cnt_r <= '0;
          if (rx_s) rx_state_r <= ST_IDLE;
        end
        default: begin
          rx_state_r <= ST_IDLE;
          rx_cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: line-level TX model, RX scoreboard, directed and random traffic.
module tb_uart_cfg;
  localparam int OS = 8;
`ifdef UART_CFG_PARITY_EN
  localparam int P_EFF = 1;
`else
  localparam int P_EFF = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_valid, loop_en, rx_drv, rx_line;
  logic [7:0] tx_data;
  logic       tx_ready, tx, rx_valid, rx_frame_err, rx_parity_err;
  logic [7:0] rx_data;
  logic [7:0] tx_data_p, rx_data_p;
  logic       tx_valid_p, tx_ready_p, tx_p, rx_p, rx_valid_p, rx_ferr_p, rx_perr_p;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_cfg dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  uart_cfg #(.PARITY(2)) dut_p (
    .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .tx(tx_p), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_frame_err(rx_ferr_p), .rx_parity_err(rx_perr_p)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rx_exp_t;

  int      n_total = 0;
  int      n_bad   = 0;
  int      cyc     = 0;
  int      p_seen  = 0;
  bit      mon_en  = 1'b0;
  bit      txq[$];
  rx_exp_t rxq[$];
  int      pulse_t[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line waveform of one default frame: start, 8 data LSB first, one stop; OS clocks each.
  function automatic void push_tx_frame(input logic [7:0] d);
    bit fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
    fb.push_back(1'b1);
    foreach (fb[i]) repeat (OS) txq.push_back(fb[i]);
  endfunction

  // Per-cycle line/handshake model and receive scoreboard.
  always @(negedge clk) begin
    logic    exp_tx, exp_rdy;
    rx_exp_t e;
    cyc++;
    if (mon_en) begin
      exp_rdy = !rst && (txq.size() <= 1);
      if (txq.size() > 0) exp_tx = txq.pop_front();
      else exp_tx = 1'b1;
      check_eq("tx_ready", {31'd0, tx_ready}, {31'd0, exp_rdy});
      check_eq("tx_line", {31'd0, tx}, {31'd0, exp_tx});
      if (rst) begin
        txq.delete();
        rxq.delete();
      end else if (tx_valid && exp_rdy) begin
        push_tx_frame(tx_data);
        if (loop_en) rxq.push_back('{tx_data, 1'b0, 1'b0});
      end
      if (rx_valid === 1'b1) begin
        pulse_t.push_back(cyc);
        if (rxq.size() == 0) begin
          check_eq("rx_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = rxq.pop_front();
          check_eq("rx_data", {24'd0, rx_data}, {24'd0, e.d});
          check_eq("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, e.fe});
          check_eq("rx_parity_err", {31'd0, rx_parity_err}, {31'd0, e.pe});
        end
      end
    end
    if (rx_valid_p === 1'b1) p_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit to_p, input int gl);
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < OS; t++) begin
        logic v;
        v = bits[k] ^ ((k == gl && t == 4) ? 1'b1 : 1'b0);
        if (to_p) rx_p = v;
        else rx_drv = v;
        tick();
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((txq.size() != 0 || rxq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", txq.size() + rxq.size(), 32'd0);
    repeat (12) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] pw [2];
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; loop_en = 1'b1; rx_drv = 1'b1;
    tx_valid_p = 1'b0; tx_data_p = 8'h00; rx_p = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    check_eq("rst_perr", {31'd0, rx_parity_err}, 32'd0);
    check_eq("rst_tx_p", {31'd0, tx_p}, 32'd1);
    check_eq("rst_ready_p", {31'd0, tx_ready_p}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single 0xA5 frame; tx_ready returns on clock 80 after the handshake.
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (78) tick();
    @(negedge clk);
    check_eq("a5_ready_79", {31'd0, tx_ready}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("a5_ready_80", {31'd0, tx_ready}, 32'd1);
    drain();

    // Gapless loopback of 00, FF, 55 with tx_valid held.
    pulse_t.delete();
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    repeat (80) tick();
    tx_data = 8'h55;
    repeat (80) tick();
    tx_valid = 1'b0;
    drain();
    check_eq("loop_pulses", pulse_t.size(), 32'd3);
    if (pulse_t.size() == 3) begin
      check_eq("loop_gap1", pulse_t[1] - pulse_t[0], 32'd80);
      check_eq("loop_gap2", pulse_t[2] - pulse_t[1], 32'd80);
    end

    // False start: two low clocks must not produce a word.
    loop_en = 1'b0;
    pulse_t.delete();
    rx_drv = 1'b0;
    repeat (2) tick();
    rx_drv = 1'b1;
    repeat (30) tick();
    check_eq("false_start", pulse_t.size(), 32'd0);

    // Single-clock glitches inside random bits are voted out.
    for (int f = 0; f < 4; f++) begin
      d = 8'($urandom);
      rxq.push_back('{d, 1'b0, 1'b0});
      send_bits({6'd0, 1'b1, d, 1'b0}, 10, 1'b0, $urandom_range(1, 9));
    end
    drain();

    // Stop bit low, line held low: one framing-error word, then silence until a new start.
    pulse_t.delete();
    d = 8'($urandom);
    rxq.push_back('{d, 1'b1, 1'b0});
    send_bits({6'd0, 1'b0, d, 1'b0}, 10, 1'b0, -1);
    repeat (40) tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    check_eq("ferr_pulses", pulse_t.size(), 32'd1);
    d = 8'($urandom);
    rxq.push_back('{d, 1'b0, 1'b0});
    send_bits({6'd0, 1'b1, d, 1'b0}, 10, 1'b0, -1);
    drain();

    // Parity instance: parity bit on the line, then received parity checks.
    pw[0] = 8'h07; pw[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      tx_data_p = pw[w]; tx_valid_p = 1'b1;
      tick();
      tx_valid_p = 1'b0;
      repeat (68) tick();
      @(negedge clk);
      check_eq("p_bit7", {31'd0, tx_p}, {31'd0, pw[w][7]});
      repeat (8) tick();
      @(negedge clk);
      check_eq("p_parbit", {31'd0, tx_p}, (P_EFF == 1) ? {31'd0, ^pw[w]} : 32'd1);
      repeat (2 + 8 * P_EFF) tick();
      @(negedge clk);
      check_eq("p_ready_early", {31'd0, tx_ready_p}, 32'd0);
      tick();
      @(negedge clk);
      check_eq("p_ready_end", {31'd0, tx_ready_p}, 32'd1);
      repeat (10) tick();
    end
    p_seen = 0;
    send_bits({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1, -1);
    rx_p = 1'b1;
    repeat (20) tick();
    check_eq("p_bad_pulses", p_seen, 32'd1);
    check_eq("p_bad_data", {24'd0, rx_data_p}, 32'h07);
    check_eq("p_bad_perr", {31'd0, rx_perr_p}, (P_EFF == 1) ? 32'd1 : 32'd0);
    check_eq("p_bad_ferr", {31'd0, rx_ferr_p}, (P_EFF == 1) ? 32'd0 : 32'd1);
    p_seen = 0;
    send_bits({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1, -1);
    repeat (20) tick();
    check_eq("p_good_pulses", p_seen, 32'd1);
    check_eq("p_good_perr", {31'd0, rx_perr_p}, 32'd0);
    check_eq("p_good_ferr", {31'd0, rx_ferr_p}, 32'd0);

    // Reset at clock 30 of a looped-back frame abandons both directions.
    loop_en = 1'b1;
    pulse_t.delete();
    tx_data = 8'($urandom); tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
    repeat (100) tick();
    check_eq("rst_no_rx", pulse_t.size(), 32'd0);
    tx_data = 8'($urandom); tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    drain();
    check_eq("rst_next_frame", pulse_t.size(), 32'd1);

    // Random independent TX and RX traffic at the same time.
    loop_en = 1'b0;
    fork
      begin
        repeat (1200) begin
          tx_valid = ($urandom_range(0, 3) == 0);
          tx_data  = 8'($urandom);
          tick();
        end
        tx_valid = 1'b0;
      end
      begin
        repeat (8) begin
          logic [7:0] rd;
          rd = 8'($urandom);
          rxq.push_back('{rd, 1'b0, 1'b0});
          send_bits({6'd0, 1'b1, rd, 1'b0}, 10, 1'b0, $urandom_range(0, 12));
          repeat ($urandom_range(0, 20)) tick();
        end
      end
    join
    drain();

    // Random loopback traffic.
    loop_en = 1'b1;
    repeat (800) begin
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
